// File: rtl/float_copro_ctrl_pkg.sv
// rtl/float_copro_ctrl_pkg.sv - opcodes, state type and opcode classifier for float_copro_ctrl
package float_copro_ctrl_pkg;

    localparam logic [10:0] FOP_ADD    = 11'd0;
    localparam logic [10:0] FOP_SUB    = 11'd1;
    localparam logic [10:0] FOP_MUL    = 11'd2;
    localparam logic [10:0] FOP_STATUS = 11'd7;
    localparam logic [10:0] FOP_CLEAR  = 11'd8;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } copro_state_t;

    typedef enum logic [1:0] {
        CLS_ARITH,
        CLS_STATUS,
        CLS_CLEAR,
        CLS_ILLEGAL
    } op_class_t;

    function automatic op_class_t classify(input logic [10:0] op);
        op_class_t cls;
        case (op)
            FOP_ADD, FOP_SUB, FOP_MUL: cls = CLS_ARITH;
            FOP_STATUS:                cls = CLS_STATUS;
            FOP_CLEAR:                 cls = CLS_CLEAR;
            default:                   cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/float_copro_ctrl.sv
// rtl/float_copro_ctrl.sv - UDI sequencer for the float coprocessor datapath with status register
//
// Ports:
//   clk_i, rst_ni                        clock, synchronous active-low reset
//   user_valid_i, user_opcode_i,
//   user_operand_0_i, user_operand_1_i   CPU request
//   user_result_o, user_complete_o       CPU response (result valid during the complete pulse)
//   busy_o                               high while an accepted request is in flight
//   dp_opcode_o, dp_op0_o, dp_op1_o      registered request held stable for the datapath
//   dp_result_i                          combinational datapath result
module float_copro_ctrl
    import float_copro_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        user_valid_i,
    input  logic [10:0] user_opcode_i,
    input  logic [31:0] user_operand_0_i,
    input  logic [31:0] user_operand_1_i,
    output logic [31:0] user_result_o,
    output logic        user_complete_o,
    output logic        busy_o,
    output logic [10:0] dp_opcode_o,
    output logic [31:0] dp_op0_o,
    output logic [31:0] dp_op1_o,
    input  logic [31:0] dp_result_i
);

    // The counter runs LATENCY-1 .. 0 in EXEC; the capture happens on the
    // cycle it reads zero, giving the datapath exactly LATENCY held cycles.
    localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

    copro_state_t     state;
    logic [3:0]       wait_cnt;
    logic             err;
    logic [CNT_W-1:0] op_count;
    logic [15:0]      cnt16;
    logic [31:0]      status_word;

    // The status word has a 16-bit count field regardless of CNT_W.
    generate
        if (CNT_W >= 16) begin : g_cnt_trunc
            assign cnt16 = op_count[15:0];
        end else begin : g_cnt_ext
            assign cnt16 = {{(16 - CNT_W){1'b0}}, op_count};
        end
    endgenerate

    assign status_word = {cnt16, 15'b0, err};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state           <= IDLE;
            user_result_o   <= '0;
            user_complete_o <= 1'b0;
            busy_o          <= 1'b0;
            dp_opcode_o     <= '0;
            dp_op0_o        <= '0;
            dp_op1_o        <= '0;
            err             <= 1'b0;
            op_count        <= '0;
            wait_cnt        <= '0;
        end else begin
            user_complete_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (user_valid_i) begin
                        dp_opcode_o <= user_opcode_i;
                        dp_op0_o    <= user_operand_0_i;
                        dp_op1_o    <= user_operand_1_i;
                        busy_o      <= 1'b1;
                        case (classify(user_opcode_i))
                            CLS_ARITH: begin
                                wait_cnt <= WAIT_INIT;
                                state    <= EXEC;
                            end
                            CLS_STATUS: begin
                                user_result_o   <= status_word;
                                user_complete_o <= 1'b1;
                                state           <= DONE;
                            end
                            CLS_CLEAR: begin
                                err             <= 1'b0;
                                op_count        <= '0;
                                user_result_o   <= '0;
                                user_complete_o <= 1'b1;
                                state           <= DONE;
                            end
                            default: begin
                                err             <= 1'b1;
                                user_result_o   <= '0;
                                user_complete_o <= 1'b1;
                                state           <= DONE;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        user_result_o   <= dp_result_i;
                        op_count        <= op_count + 1'b1;
                        user_complete_o <= 1'b1;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_copro_ctrl.sv
// tb/tb_float_copro_ctrl.sv - self-checking bench for float_copro_ctrl with a cycle-level reference model
module tb_float_copro_ctrl;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [10:0] opc;
    logic [31:0] a, b;
    logic [31:0] user_result;
    logic        user_complete;
    logic        busy;
    logic [10:0] dp_opcode;
    logic [31:0] dp_op0, dp_op1;
    logic [31:0] dp_result;

    always #5 clk = ~clk;

    float_copro_ctrl #(.LATENCY(L), .CNT_W(16)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .user_valid_i     (valid),
        .user_opcode_i    (opc),
        .user_operand_0_i (a),
        .user_operand_1_i (b),
        .user_result_o    (user_result),
        .user_complete_o  (user_complete),
        .busy_o           (busy),
        .dp_opcode_o      (dp_opcode),
        .dp_op0_o         (dp_op0),
        .dp_op1_o         (dp_op1),
        .dp_result_i      (dp_result)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Datapath stand-in: known float vectors, otherwise a synthetic mix.
    function automatic logic [31:0] dp_func(input logic [10:0] op, input logic [31:0] x, input logic [31:0] y);
        if (op == 11'd0 && x == 32'h3F800000 && y == 32'h40000000) return 32'h40400000;
        if (op == 11'd0 && x == 32'h3F800000 && y == 32'h3F800000) return 32'h40000000;
        if (op == 11'd1 && x == 32'h40400000 && y == 32'h3F800000) return 32'h40000000;
        if (op == 11'd2 && x == 32'h40000000 && y == 32'h40400000) return 32'h40C00000;
        return x ^ {y[15:0], y[31:16]} ^ {21'd0, op};
    endfunction

    // Multicycle behaviour: the result is garbage until the inputs have been
    // stable for L full cycles.
    int          held = 0;
    logic [10:0] last_op = '0;
    logic [31:0] last_a = '0, last_b = '0;
    always @(negedge clk) begin
        if (dp_opcode == last_op && dp_op0 == last_a && dp_op1 == last_b) held <= held + 1;
        else held <= 1;
        last_op <= dp_opcode;
        last_a  <= dp_op0;
        last_b  <= dp_op1;
    end
    always_comb begin
        dp_result = 32'hBAD0BAD0;
        if (held >= L) dp_result = dp_func(dp_opcode, dp_op0, dp_op1);
    end

    // Reference model: "remaining" is the number of busy cycles still ahead,
    // counted from the cycle that follows the current clock edge.
    int          remaining = 0;
    bit          pend = 0;
    logic [10:0] m_op = '0;
    logic [31:0] m_a = '0, m_b = '0, m_result = '0;
    logic        m_err = 0;
    logic [15:0] m_cnt = '0;

    int          obs_n = 0;
    int          obs_cyc = 0;
    logic [31:0] obs_res = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            remaining = 0; pend = 0;
            m_op = '0; m_a = '0; m_b = '0; m_result = '0; m_err = 0; m_cnt = '0;
        end else if (remaining > 0) begin
            remaining--;
            if (remaining == 1 && pend) begin
                m_result = dp_func(m_op, m_a, m_b);
                m_cnt++;
                pend = 0;
            end
        end else if (valid) begin
            m_op = opc; m_a = a; m_b = b;
            if (opc <= 11'd2) begin
                remaining = L + 1;
                pend = 1;
            end else begin
                remaining = 1;
                if (opc == 11'd7) m_result = {m_cnt, 15'b0, m_err};
                else if (opc == 11'd8) begin m_err = 0; m_cnt = '0; m_result = '0; end
                else begin m_err = 1; m_result = '0; end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        chk("complete", {31'd0, user_complete}, {31'd0, remaining == 1});
        chk("busy", {31'd0, busy}, {31'd0, remaining > 0});
        chk("result", user_result, m_result);
        chk("dp_opcode", {21'd0, dp_opcode}, {21'd0, m_op});
        chk("dp_op0", dp_op0, m_a);
        chk("dp_op1", dp_op1, m_b);
        if (user_complete) begin
            obs_n++;
            obs_cyc = cyc;
            obs_res = user_result;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_cpl(input string name);
        bit hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (remaining == 1) hit = 1;
        end
        if (!hit) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic req(input logic [10:0] o, input logic [31:0] x, input logic [31:0] y);
        valid = 1'b1; opc = o; a = x; b = y;
    endtask

    int vcyc;
    int n0;

    initial begin
        rst_n = 1'b0; valid = 1'b0; opc = '0; a = '0; b = '0;
        steps(2);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_result", user_result, 32'd0);
        rst_n = 1'b1;
        steps(2);

        // sub then mul, valid held through DONE
        n0 = obs_n;
        req(11'd1, 32'h40400000, 32'h3F800000);
        run_until_cpl("sub");
        chk("sub_lit", obs_res, 32'h40000000);
        req(11'd2, 32'h40000000, 32'h40400000);
        run_until_cpl("mul");
        chk("mul_lit", obs_res, 32'h40C00000);
        valid = 1'b0;
        steps(6);
        chk("submul_count", obs_n - n0, 32'd2);

        // illegal opcode then status
        req(11'd5, 32'h11223344, 32'h55667788);
        vcyc = cyc + 1;
        step();
        valid = 1'b0;
        steps(3);
        chk("illegal_lat", obs_cyc - vcyc + 1, 32'd1);
        chk("illegal_lit", obs_res, 32'd0);
        req(11'd7, 32'd0, 32'd0);
        step();
        valid = 1'b0;
        steps(3);
        chk("status_lit", obs_res, 32'h00020001);

        // clear then status
        req(11'd8, 32'd0, 32'd0);
        vcyc = cyc + 1;
        step();
        valid = 1'b0;
        steps(3);
        chk("clear_lat", obs_cyc - vcyc + 1, 32'd1);
        chk("clear_lit", obs_res, 32'd0);
        req(11'd7, 32'd0, 32'd0);
        step();
        valid = 1'b0;
        steps(3);
        chk("status2_lit", obs_res, 32'd0);

        // add latency
        req(11'd0, 32'h3F800000, 32'h40000000);
        vcyc = cyc + 1;
        step();
        valid = 1'b0;
        steps(6);
        chk("add_lat", obs_cyc - vcyc + 1, 32'd4);
        chk("add_lit", obs_res, 32'h40400000);

        // valid pulses during EXEC are ignored
        n0 = obs_n;
        req(11'd0, 32'h3F800000, 32'h3F800000);
        step();
        req(11'd1, 32'h12345678, 32'h9ABCDEF0);
        step();
        valid = 1'b0;
        step();
        req(11'd2, 32'h11111111, 32'h22222222);
        step();
        valid = 1'b0;
        steps(5);
        chk("exec_ign_lit", obs_res, 32'h40000000);
        chk("exec_ign_op1", dp_op1, 32'h3F800000);
        chk("exec_ign_count", obs_n - n0, 32'd1);

        // reset in the middle of EXEC
        n0 = obs_n;
        req(11'd0, 32'h3F800000, 32'h40000000);
        step();
        valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        steps(5);
        chk("abort_count", obs_n - n0, 32'd0);
        chk("abort_dp_op0", dp_op0, 32'd0);
        req(11'd0, 32'h3F800000, 32'h40000000);
        vcyc = cyc + 1;
        step();
        valid = 1'b0;
        steps(6);
        chk("post_rst_lat", obs_cyc - vcyc + 1, 32'd4);
        chk("post_rst_lit", obs_res, 32'h40400000);
        req(11'd7, 32'd0, 32'd0);
        step();
        valid = 1'b0;
        steps(3);
        chk("post_rst_status", obs_res, 32'h00010000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/float_copro_ctrl.md
Name: float_copro_ctrl

Overview:
- Sequencing front-end between the LM32 user-defined-instruction (UDI) port and the combinational float coprocessor datapath (add, sub, mul).
- Accepts one request from the CPU and registers the opcode and operands.
- Holds them stable on the datapath inputs for a programmable multicycle window, then captures the datapath result and returns it with a one-cycle complete pulse.
- Also owns a small status register: a sticky illegal-opcode flag and a count of completed operations, readable and clearable through reserved opcodes.

Parameters:
- LATENCY, 3, cycles the datapath inputs are held before the result is sampled (legal range 1..15).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous reset, active-low
- user_valid_i  in  1  CPU request strobe
- user_opcode_i  in  11  CPU opcode
- user_operand_0_i  in  32  first IEEE-754 single operand
- user_operand_1_i  in  32  second IEEE-754 single operand
- user_result_o  out  32  result returned to the CPU
- user_complete_o  out  1  one-cycle completion pulse
- busy_o  out  1  high while in EXEC or DONE
- dp_opcode_o  out  11  registered opcode to the datapath
- dp_op0_o  out  32  registered operand 0 to the datapath
- dp_op1_o  out  32  registered operand 1 to the datapath
- dp_result_i  in  32  combinational datapath result

Behaviour:
- Reset (rst_ni low at a clock edge) forces state IDLE and zeroes all of the following: user_result_o, user_complete_o, busy_o, dp_opcode_o, dp_op0_o, dp_op1_o, the err flag, the op counter and the wait counter.
- Reset has priority over every other event, including mid-EXEC and in DONE; an aborted operation never completes.
- Opcode classes:
  - ARITH: 0 add, 1 sub, 2 mul.
  - STATUS: 7.
  - CLEAR: 8.
  - Every other value is ILLEGAL.
- IDLE:
  - When user_valid_i = 1, latch opcode and both operands into dp_opcode_o / dp_op0_o / dp_op1_o.
  - ARITH: load wait counter with LATENCY-1 and go to EXEC.
  - STATUS, CLEAR or ILLEGAL: go straight to DONE, with the result prepared as defined below.
- EXEC:
  - dp_* outputs stay constant; the datapath is a multicycle path of LATENCY cycles.
  - While the counter is nonzero, decrement it.
  - When the counter is 0, capture dp_result_i into user_result_o, increment the op counter (wraps 2^CNT_W-1 -> 0) and go to DONE.
- DONE: user_complete_o = 1 for exactly this cycle, then go to IDLE. user_valid_i is ignored in DONE.
- Latency from the valid edge to complete:
  - ARITH: LATENCY+1 cycles.
  - STATUS, CLEAR, ILLEGAL: 1 cycle.
- Results for non-arithmetic opcodes:
  - STATUS: user_result_o = {op_count zero-extended or truncated into [31:16], 15'b0, err}.
  - CLEAR: err = 0, op_count = 0, user_result_o = 0.
  - ILLEGAL: err = 1 (sticky), user_result_o = 0, op counter unchanged.
- user_result_o holds its last value until the next capture. It is only meaningful while user_complete_o = 1.
- user_valid_i seen while busy (EXEC/DONE) is ignored and never queued.
- If user_valid_i is still high in the IDLE cycle after DONE, it is treated as a new request. The CPU must deassert valid on the cycle complete is seen.
- ARITH results are taken unmodified from the datapath; this block does no float arithmetic.

Decomposition:
- float_pack gains:
  - opcode localparams FOP_ADD = 11'd0, FOP_SUB = 11'd1, FOP_MUL = 11'd2, FOP_STATUS = 11'd7, FOP_CLEAR = 11'd8;
  - an enum typedef copro_state_t {IDLE, EXEC, DONE}.
- No sub-module: FSM, wait counter and status register live in one module.
- The integration top instantiates float_copro_ctrl together with float_copro_dp and wires dp_* ports to the datapath's opcode, op0, op1 and result.

Test Plan:
- Add, LATENCY = 3: valid with opcode 0, op0 = 0x3F800000, op1 = 0x40000000 -> complete pulses exactly 4 cycles after valid, result 0x40400000; busy_o high for those 4 cycles.
- Sub then mul back-to-back, valid held through DONE:
  - opcode 1, 0x40400000 - 0x3F800000 -> 0x40000000;
  - opcode 2, 0x40000000 * 0x40400000 -> 0x40C00000;
  - no third spurious completion once valid drops.
- Illegal opcode 5 -> complete 1 cycle later, result 0. A following STATUS (opcode 7) returns 0x00020001 after the two prior arithmetic ops (count 2, err 1).
- CLEAR (opcode 8) -> result 0, complete after 1 cycle. A subsequent STATUS returns 0x00000000.
- Valid pulses with different operands during EXEC -> ignored; dp_op0_o / dp_op1_o unchanged, and the original operation's result is returned.
- rst_ni low for one cycle in the middle of EXEC -> no complete pulse, all outputs 0, state IDLE. A new add request afterwards completes normally in LATENCY+1 cycles.
